// File: rtl/wb_patch_master_if.sv
// Command/response handshake and Wishbone classic bus bundle for wb_patch_master.
// The master modport is the block's own view; slave is the loader/memory side.
interface wb_patch_master_if #(
   parameter int DATA_WIDTH = 11,
   parameter int PATCH_SIZE = 5,
   parameter int ADDR_WIDTH = 9
);
   localparam int PW = DATA_WIDTH * PATCH_SIZE;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_we;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [PW-1:0]         cmd_wpatch;
   logic                  rsp_valid;
   logic                  rsp_err;
   logic [PW-1:0]         rsp_rpatch;
   logic                  wbm_cyc_o;
   logic                  wbm_stb_o;
   logic                  wbm_we_o;
   logic [3:0]            wbm_sel_o;
   logic [31:0]           wbm_adr_o;
   logic [31:0]           wbm_dat_o;
   logic                  wbm_ack_i;
   logic [31:0]           wbm_dat_i;

   modport master (
      input  cmd_valid, cmd_we, cmd_addr, cmd_wpatch, wbm_ack_i, wbm_dat_i,
      output cmd_ready, rsp_valid, rsp_err, rsp_rpatch,
             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_addr, cmd_wpatch, wbm_ack_i, wbm_dat_i,
      input  cmd_ready, rsp_valid, rsp_err, rsp_rpatch,
             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );
endinterface

// File: rtl/wb_patch_master.sv
// Wishbone classic master moving one query patch per command as two 32-bit beats,
// with a one-cycle GAP between beats and a per-beat ack timeout.
module wb_patch_master #(
   parameter int          DATA_WIDTH = 11,
   parameter int          PATCH_SIZE = 5,
   parameter int          ADDR_WIDTH = 9,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          TIMEOUT    = 16
) (
   input logic               clk,
   input logic               rst_n,
   wb_patch_master_if.master bus
);
   localparam int W  = DATA_WIDTH * PATCH_SIZE;
   localparam int HW = W - 32;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, BEAT0, GAP, BEAT1, RESP} state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_n, err_q, err_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_n;
   logic [W-1:0]          wp_q, wp_n, rd_q, rd_n;
   logic [CW-1:0]         wait_q;
   logic                  stb, tmo, cyc_d, stb_d;

   assign stb   = (state_q == BEAT0) || (state_q == BEAT1);
   assign tmo   = (wait_q == CW'(TIMEOUT - 1));
   assign cyc_d = state_d inside {BEAT0, GAP, BEAT1};
   assign stb_d = state_d inside {BEAT0, BEAT1};

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Ack takes priority over a timeout landing on the same edge.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         IDLE:  if (bus.cmd_valid) begin state_d = BEAT0; err_d = 1'b0; end
         BEAT0: if (bus.wbm_ack_i) state_d = GAP;
                else if (tmo) begin state_d = RESP; err_d = 1'b1; end
         GAP:   state_d = BEAT1;
         BEAT1: if (bus.wbm_ack_i) state_d = RESP;
                else if (tmo) begin state_d = RESP; err_d = 1'b1; end
         RESP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      we_n   = we_q;
      addr_n = addr_q;
      wp_n   = wp_q;
      rd_n   = rd_q;
      if (state_q == IDLE && bus.cmd_valid) begin
         we_n   = bus.cmd_we;
         addr_n = bus.cmd_addr;
         wp_n   = bus.cmd_wpatch;
         rd_n   = '0;
      end
      if (state_q == BEAT0 && bus.wbm_ack_i) rd_n[31:0]  = bus.wbm_dat_i;
      if (state_q == BEAT1 && bus.wbm_ack_i) rd_n[W-1:32] = bus.wbm_dat_i[HW-1:0];
   end

   // Every output is a flop loaded from next-state values, so no input reaches a port combinationally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q           <= 1'b0;
         err_q          <= 1'b0;
         addr_q         <= '0;
         wp_q           <= '0;
         rd_q           <= '0;
         wait_q         <= '0;
         bus.cmd_ready  <= 1'b1;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_err    <= 1'b0;
         bus.rsp_rpatch <= '0;
         bus.wbm_cyc_o  <= 1'b0;
         bus.wbm_stb_o  <= 1'b0;
         bus.wbm_we_o   <= 1'b0;
         bus.wbm_sel_o  <= 4'h0;
         bus.wbm_adr_o  <= '0;
         bus.wbm_dat_o  <= '0;
      end else begin
         we_q           <= we_n;
         err_q          <= err_d;
         addr_q         <= addr_n;
         wp_q           <= wp_n;
         rd_q           <= rd_n;
         wait_q         <= (stb && state_d == state_q) ? wait_q + 1'b1 : '0;
         bus.cmd_ready  <= (state_d == IDLE);
         bus.rsp_valid  <= (state_d == RESP);
         bus.rsp_err    <= (state_d == RESP) && err_d;
         bus.rsp_rpatch <= (state_d == RESP && !we_q && !err_d) ? rd_n : '0;
         bus.wbm_cyc_o  <= cyc_d;
         bus.wbm_stb_o  <= stb_d;
         bus.wbm_we_o   <= cyc_d && we_n;
         bus.wbm_sel_o  <= stb_d ? 4'hF : 4'h0;
         if (state_d == BEAT0) begin
            bus.wbm_adr_o <= BASE_ADDR + 32'({addr_n, 1'b0, 2'b00});
            bus.wbm_dat_o <= we_n ? wp_n[31:0] : 32'h0;
         end else if (state_d == BEAT1) begin
            bus.wbm_adr_o <= BASE_ADDR + 32'({addr_n, 1'b1, 2'b00});
            bus.wbm_dat_o <= we_n ? 32'(wp_n[W-1:32]) : 32'h0;
         end else begin
            bus.wbm_adr_o <= '0;
            bus.wbm_dat_o <= '0;
         end
      end
   end
endmodule

// File: tb/tb_wb_patch_master.sv
// Directed bench for wb_patch_master: behavioural Wishbone slave with per-beat
// wait control, a bus monitor, and hand-computed expectations.
module tb_wb_patch_master;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   wb_patch_master_if #(.DATA_WIDTH(11), .PATCH_SIZE(5), .ADDR_WIDTH(9)) bus ();

   wb_patch_master #(
      .DATA_WIDTH(11), .PATCH_SIZE(5), .ADDR_WIDTH(9),
      .BASE_ADDR(32'h3000_0000), .TIMEOUT(16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---- cycle counter and accept log
   int cyc_n = 0;
   int acc_e = 0;
   int acc_q[$];
   always @(posedge clk) begin
      cyc_n = cyc_n + 1;
      if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
         acc_e = cyc_n;
         acc_q.push_back(cyc_n);
      end
   end

   // ---- slave: ack after w0/w1 wait cycles, optional spurious ack while in GAP
   logic [31:0] mem [logic [31:0]];
   int w0, w1, s_cnt;
   bit spur;
   always @(negedge clk) begin
      if (!bus.wbm_stb_o) begin
         s_cnt = 0;
         bus.wbm_ack_i = spur && bus.wbm_cyc_o;
      end else if (s_cnt >= (bus.wbm_adr_o[2] ? w1 : w0)) begin
         bus.wbm_ack_i = 1'b1;
         if (bus.wbm_we_o) mem[bus.wbm_adr_o] = bus.wbm_dat_o;
         else bus.wbm_dat_i = mem.exists(bus.wbm_adr_o) ? mem[bus.wbm_adr_o] : 32'h0;
      end else begin
         bus.wbm_ack_i = 1'b0;
         s_cnt++;
      end
   end

   // ---- monitor: beats, strobe lengths, GAP cycles, responses (cycle relative to accept)
   logic [31:0] beat_adr[$], beat_dat[$];
   int stb_len[$], rsp_rel[$];
   logic rsp_err[$];
   logic [54:0] rsp_pat[$];
   int stb_cnt, gap_n, bad_sel;
   logic stb_dly = 1'b0;
   always @(negedge clk) begin
      if (bus.wbm_stb_o && !stb_dly) begin
         beat_adr.push_back(bus.wbm_adr_o);
         beat_dat.push_back(bus.wbm_dat_o);
         stb_cnt = 0;
      end
      if (bus.wbm_stb_o) begin
         stb_cnt++;
         if (bus.wbm_sel_o != 4'hF) bad_sel++;
      end else if (stb_dly) stb_len.push_back(stb_cnt);
      if (bus.wbm_cyc_o && !bus.wbm_stb_o) gap_n++;
      if (bus.rsp_valid) begin
         rsp_rel.push_back(cyc_n - acc_e + 1);
         rsp_err.push_back(bus.rsp_err);
         rsp_pat.push_back(bus.rsp_rpatch);
      end
      stb_dly = bus.wbm_stb_o;
   end

   task automatic run_cmd(input logic we, input logic [8:0] a, input logic [54:0] wp);
      int na;
      na = acc_q.size();
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = a; bus.cmd_wpatch = wp;
      for (int i = 0; i < 50 && acc_q.size() == na; i++) begin
         @(posedge clk); #1;
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int r0, input int n);
      for (int i = 0; i < 80 && rsp_rel.size() < r0 + n; i++) begin
         @(negedge clk); #1;
      end
      chk("rsp_seen", 64'(rsp_rel.size() - r0), 64'(n));
      @(negedge clk); #1;
   endtask

   int b0, r0, g0, n0, k;

   initial begin
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wpatch = '0;
      w0 = 0; w1 = 0; spur = 1'b0; gap_n = 0; bad_sel = 0;
      mem[32'h3000_0FF8] = 32'hDEAD_BEEF;
      mem[32'h3000_0FFC] = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", bus.cmd_ready, 1);
      chk("rst_cyc_stb_we", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 0);
      chk("rst_sel_adr_dat", {bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o}, 0);
      chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rpatch}, 0);
      @(negedge clk); rst_n = 1'b1;

      // write addr 3, zero-wait slave
      b0 = beat_adr.size(); r0 = rsp_rel.size();
      run_cmd(1'b1, 9'd3, 55'h1);
      wait_rsp(r0, 1);
      chk("wr_adr0", beat_adr[b0], 32'h3000_0018);
      chk("wr_dat0", beat_dat[b0], 32'h0000_0001);
      chk("wr_adr1", beat_adr[b0+1], 32'h3000_001C);
      chk("wr_dat1", beat_dat[b0+1], 32'h0);
      chk("wr_rel", 64'(rsp_rel[r0]), 4);
      chk("wr_err", rsp_err[r0], 0);

      // read back addr 3
      r0 = rsp_rel.size();
      run_cmd(1'b0, 9'd3, '0);
      wait_rsp(r0, 1);
      chk("rd3_pat", rsp_pat[r0], 55'h1);
      chk("rd3_rel", 64'(rsp_rel[r0]), 4);

      // read top patch, upper beat truncated to 23 bits
      b0 = beat_adr.size(); r0 = rsp_rel.size();
      run_cmd(1'b0, 9'd511, '0);
      wait_rsp(r0, 1);
      chk("rd511_pat", rsp_pat[r0], 55'h7F_FFFF_DEAD_BEEF);
      chk("rd511_adr1", beat_adr[b0+1], 32'h3000_0FFC);

      // 3 wait cycles on beat1
      w1 = 3;
      b0 = beat_adr.size(); r0 = rsp_rel.size(); g0 = gap_n;
      run_cmd(1'b0, 9'd3, '0);
      wait_rsp(r0, 1);
      chk("wait_stb0", 64'(stb_len[b0]), 1);
      chk("wait_stb1", 64'(stb_len[b0+1]), 4);
      chk("wait_rel", 64'(rsp_rel[r0]), 7);
      chk("wait_gap", 64'(gap_n - g0), 1);
      w1 = 0;

      // beat0 never acked
      w0 = 1000;
      b0 = beat_adr.size(); r0 = rsp_rel.size(); g0 = gap_n;
      run_cmd(1'b0, 9'd511, '0);
      wait_rsp(r0, 1);
      chk("tmo_stb", 64'(stb_len[b0]), 16);
      chk("tmo_rel", 64'(rsp_rel[r0]), 17);
      chk("tmo_err", rsp_err[r0], 1);
      chk("tmo_pat", rsp_pat[r0], 0);
      chk("tmo_beats", 64'(beat_adr.size() - b0), 1);
      chk("tmo_gap", 64'(gap_n - g0), 0);
      w0 = 0;

      // three queued reads with valid held high, spurious ack during GAP
      spur = 1'b1; k = 0;
      n0 = acc_q.size(); b0 = beat_adr.size(); r0 = rsp_rel.size();
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 9'd3;
      for (int i = 0; i < 40 && k < 3; i++) begin
         @(posedge clk); #1;
         if (acc_q.size() > n0 + k) begin
            k++;
            bus.cmd_addr = (k == 1) ? 9'd511 : 9'd3;
            if (k == 3) bus.cmd_valid = 1'b0;
         end
      end
      bus.cmd_valid = 1'b0;
      wait_rsp(r0, 3);
      chk("q_acc_gap1", 64'(acc_q[n0+1] - acc_q[n0]), 5);
      chk("q_acc_gap2", 64'(acc_q[n0+2] - acc_q[n0+1]), 5);
      chk("q_adr_a", beat_adr[b0], 32'h3000_0018);
      chk("q_adr_b", beat_adr[b0+2], 32'h3000_0FF8);
      chk("q_adr_c", beat_adr[b0+4], 32'h3000_0018);
      chk("q_rel_b", 64'(rsp_rel[r0+1]), 4);
      chk("q_pat_b", rsp_pat[r0+1], 55'h7F_FFFF_DEAD_BEEF);
      chk("q_pat_c", rsp_pat[r0+2], 55'h1);
      spur = 1'b0;

      // reset asserted during BEAT1 of a write
      w1 = 5;
      r0 = rsp_rel.size();
      run_cmd(1'b1, 9'd7, 55'h12_3456_789A_BCDE);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_beat1", {bus.wbm_stb_o, bus.wbm_adr_o}, {1'b1, 32'h3000_003C});
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 0);
      chk("rst_mid_ready", bus.cmd_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      chk("rst_no_rsp", 64'(rsp_rel.size() - r0), 0);
      w1 = 0;

      // normal write after the reset
      b0 = beat_adr.size(); r0 = rsp_rel.size();
      run_cmd(1'b1, 9'd2, 55'h12_3456_789A_BCDE);
      wait_rsp(r0, 1);
      chk("post_adr0", beat_adr[b0], 32'h3000_0010);
      chk("post_dat0", beat_dat[b0], 32'h789A_BCDE);
      chk("post_dat1", beat_dat[b0+1], 32'h0012_3456);
      chk("post_rel", 64'(rsp_rel[r0]), 4);
      chk("post_err", rsp_err[r0], 0);

      chk("sel_all_beats", 64'(bad_sel), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
